// File: rtl/internet_scheduler.sv
// internet_scheduler: round-robin time-slice arbiter for the shared internet
// link. Drives the demux Enable/Sel pair plus a one-hot grant copy and the
// remaining slice count. One idle guard cycle separates consecutive grants.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; arbitrate on every edge
// GRANT | link routed to Sel; counting down the slice
// GUARD | single dead cycle after a grant; arbitrate at its closing edge
module internet_scheduler #(
  parameter int unsigned SLICE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Req,
  input  logic [3:0] Done,
  output logic       Enable,
  output logic [1:0] Sel,
  output logic [3:0] Grant,
  output logic [7:0] SliceLeft
);

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  localparam logic [7:0] SLICE_LOAD = 8'(SLICE - 1);

  state_t     state;
  logic [1:0] last;
  logic [7:0] cnt;

  logic       win_valid;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       grant_end;

  // Rotating priority: Last+1 first, Last itself last. Scanning from the
  // farthest offset down lets the nearest requester overwrite the result.
  always_comb begin
    winner    = last;
    cand      = '0;
    win_valid = |Req;
    for (int i = 3; i >= 1; i--) begin
      cand = last + 2'(i);
      if (Req[cand]) winner = cand;
    end
  end

  // Only the current holder's Req/Done bits can end its slice.
  always_comb begin
    grant_end = (cnt == 8'd0) || !Req[Sel] || Done[Sel];
  end

  // Scheduler FSM with registered outputs; Sel moves only when a grant starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 2'd3;
      cnt    <= 8'd0;
      Enable <= 1'b0;
      Sel    <= 2'd0;
      Grant  <= 4'd0;
    end else begin
      case (state)
        IDLE, GUARD: begin
          if (win_valid) begin
            state  <= GRANT;
            Sel    <= winner;
            Grant  <= 4'b0001 << winner;
            Enable <= 1'b1;
            cnt    <= SLICE_LOAD;
          end else begin
            state  <= IDLE;
          end
        end
        GRANT: begin
          if (grant_end) begin
            state  <= GUARD;
            Enable <= 1'b0;
            Grant  <= 4'd0;
            cnt    <= 8'd0;
            last   <= Sel;
          end else begin
            cnt    <= cnt - 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          Enable <= 1'b0;
          Grant  <= 4'd0;
          cnt    <= 8'd0;
        end
      endcase
    end
  end

  assign SliceLeft = cnt;

endmodule
